sigma_bridge_driver: RTL and testbench

SIGMA_BRIDGE_DRIVER -- requirements
Module: sigma_bridge_driver

---
 rtl/hybrid_ctrl_pkg.sv | 37 +++
 rtl/sat_counter.sv | 36 +++
 rtl/sigma_bridge_driver.sv | 142 ++++++++++++++
 tb/tb_sigma_bridge_driver.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/hybrid_ctrl_pkg.sv
// Shared definitions for the hybrid-controller bridge driver: FSM encoding,
// gate patterns and default widths.
package hybrid_ctrl_pkg;

    localparam int unsigned DT_W_DEF = 8;
    localparam int unsigned DW_W_DEF = 16;
    localparam int unsigned GATE_W   = 4;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_DEAD = 2'd1,
        ST_ON_P = 2'd2,
        ST_ON_N = 2'd3
    } state_e;

    // Gate drive order is {Q4,Q3,Q2,Q1}
    localparam logic [GATE_W-1:0] GATE_OFF = 4'b0000;
    localparam logic [GATE_W-1:0] GATE_P   = 4'b1001;
    localparam logic [GATE_W-1:0] GATE_N   = 4'b0110;

    typedef struct packed {
        logic [GATE_W-1:0] gate;
        logic              dead;
    } bridge_out_t;

    function automatic logic [GATE_W-1:0] gate_for(input state_e st);
        logic [GATE_W-1:0] g;
        g = GATE_OFF;
        unique case (st)
            ST_ON_P: g = GATE_P;
            ST_ON_N: g = GATE_N;
            default: g = GATE_OFF;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and saturation at all-ones.
module sat_counter
    import hybrid_ctrl_pkg::*;
#(
    parameter int unsigned W = DW_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_count = cnt_q;

endmodule

// File: rtl/sigma_bridge_driver.sv
// H-bridge gate driver: turns the controller's switching variable into
// non-overlapping leg-pair drives with dead time and minimum dwell.
module sigma_bridge_driver
    import hybrid_ctrl_pkg::*;
#(
    parameter int unsigned DT_W = DT_W_DEF,
    parameter int unsigned DW_W = DW_W_DEF
) (
    input  logic              i_clock,
    input  logic              i_RESET,
    input  logic              i_enable,
    input  logic              i_sigma,
    input  logic [DT_W-1:0]   i_deadtime,
    input  logic [DW_W-1:0]   i_min_dwell,
    output logic [GATE_W-1:0] o_gate,
    output logic              o_sigma_applied,
    output logic              o_dead,
    output logic [DW_W-1:0]   o_sw_count
);

    state_e            state_q, state_d;
    logic              sigma_q, sigma_d;
    logic              arm_q, arm_d;
    logic              target_q, target_d;
    logic              pol_q, pol_d;
    logic              from_off_q, from_off_d;
    logic [DT_W-1:0]   dt_lim_q, dt_lim_d;
    logic [DW_W-1:0]   min_dw_q, min_dw_d;
    logic [DW_W-1:0]   sw_cnt_q, sw_cnt_d;
    bridge_out_t       out_q, out_d;

    logic [DT_W-1:0]   dead_cnt;
    logic [DW_W-1:0]   dwell_cnt;
    logic [DT_W-1:0]   dt_load;
    logic              dead_done;
    logic              dwell_met;
    logic              cur_pol;

    sat_counter #(.W(DT_W)) u_dead_cnt (
        .clk     (i_clock),
        .rst_n   (i_RESET),
        .i_clr   (state_q != ST_DEAD),
        .i_en    (state_q == ST_DEAD),
        .o_count (dead_cnt)
    );

    sat_counter #(.W(DW_W)) u_dwell_cnt (
        .clk     (i_clock),
        .rst_n   (i_RESET),
        .i_clr   ((state_q != ST_ON_P) && (state_q != ST_ON_N)),
        .i_en    ((state_q == ST_ON_P) || (state_q == ST_ON_N)),
        .o_count (dwell_cnt)
    );

    // A zero dead time still gets one gates-off cycle
    assign dt_load   = (i_deadtime == '0) ? DT_W'(1) : i_deadtime;
    assign dead_done = (dead_cnt >= (dt_lim_q - DT_W'(1)));
    assign dwell_met = (dwell_cnt >= min_dw_q);
    assign cur_pol   = (state_q == ST_ON_P);

    always_comb begin
        sigma_d    = i_sigma;
        arm_d      = 1'b1;
        state_d    = state_q;
        target_d   = target_q;
        pol_d      = pol_q;
        from_off_d = from_off_q;
        dt_lim_d   = dt_lim_q;
        min_dw_d   = min_dw_q;
        sw_cnt_d   = sw_cnt_q;

        // The first edge after reset release only arms the FSM
        if (!arm_q || !i_enable) begin
            state_d = ST_OFF;
        end else begin
            unique case (state_q)
                ST_OFF: begin
                    state_d    = ST_DEAD;
                    target_d   = sigma_q;
                    from_off_d = 1'b1;
                    dt_lim_d   = dt_load;
                end
                ST_DEAD: begin
                    if (dead_done) begin
                        state_d    = target_q ? ST_ON_P : ST_ON_N;
                        pol_d      = target_q;
                        from_off_d = 1'b0;
                        min_dw_d   = i_min_dwell;
                        if (!from_off_q && (target_q != pol_q)) begin
                            sw_cnt_d = sw_cnt_q + DW_W'(1);
                        end
                    end
                end
                ST_ON_P, ST_ON_N: begin
                    // Held-off requests simply keep re-evaluating until dwell is met
                    if ((sigma_q != cur_pol) && dwell_met) begin
                        state_d  = ST_DEAD;
                        target_d = sigma_q;
                        dt_lim_d = dt_load;
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end

        out_d.gate = gate_for(state_d);
        out_d.dead = (state_d == ST_OFF) || (state_d == ST_DEAD);
    end

    always_ff @(posedge i_clock or negedge i_RESET) begin
        if (!i_RESET) begin
            state_q    <= ST_OFF;
            sigma_q    <= 1'b1;
            arm_q      <= 1'b0;
            target_q   <= 1'b1;
            pol_q      <= 1'b1;
            from_off_q <= 1'b0;
            dt_lim_q   <= '0;
            min_dw_q   <= '0;
            sw_cnt_q   <= '0;
            out_q.gate <= GATE_OFF;
            out_q.dead <= 1'b1;
        end else begin
            state_q    <= state_d;
            sigma_q    <= sigma_d;
            arm_q      <= arm_d;
            target_q   <= target_d;
            pol_q      <= pol_d;
            from_off_q <= from_off_d;
            dt_lim_q   <= dt_lim_d;
            min_dw_q   <= min_dw_d;
            sw_cnt_q   <= sw_cnt_d;
            out_q      <= out_d;
        end
    end

    assign o_gate          = out_q.gate;
    assign o_dead          = out_q.dead;
    assign o_sigma_applied = pol_q;
    assign o_sw_count      = sw_cnt_q;

endmodule

// File: tb/tb_sigma_bridge_driver.sv
// Bench for sigma_bridge_driver: timeline model checked every cycle plus
// hand-computed checkpoints for the directed scenarios.
module tb_sigma_bridge_driver;

    localparam int unsigned DT_W   = 8;
    localparam int unsigned DW_W   = 16;
    localparam int          DW_MAX = 65535;

    logic            i_clock    = 1'b0;
    logic            i_RESET    = 1'b1;
    logic            i_enable   = 1'b0;
    logic            i_sigma    = 1'b1;
    logic [DT_W-1:0] i_deadtime = 8'd5;
    logic [DW_W-1:0] i_min_dwell = 16'd0;
    logic [3:0]      o_gate;
    logic            o_sigma_applied;
    logic            o_dead;
    logic [DW_W-1:0] o_sw_count;

    int n_checks = 0;
    int n_errors = 0;

    sigma_bridge_driver #(.DT_W(DT_W), .DW_W(DW_W)) dut (
        .i_clock         (i_clock),
        .i_RESET         (i_RESET),
        .i_enable        (i_enable),
        .i_sigma         (i_sigma),
        .i_deadtime      (i_deadtime),
        .i_min_dwell     (i_min_dwell),
        .o_gate          (o_gate),
        .o_sigma_applied (o_sigma_applied),
        .o_dead          (o_dead),
        .o_sw_count      (o_sw_count)
    );

    always #5 i_clock = ~i_clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // Model: mode 0 = gates off, 1 = dead-time countdown, 2 = conducting
    int m_mode, m_sig, m_arm, m_pol, m_tgt, m_left, m_age, m_min, m_sw, m_first;

    task automatic model_reset();
        m_mode = 0; m_sig = 1; m_arm = 0; m_pol = 1; m_tgt = 1;
        m_left = 0; m_age = 0; m_min = 0; m_sw = 0; m_first = 0;
    endtask

    function automatic int dead_len(input logic [DT_W-1:0] d);
        return (d == 0) ? 1 : int'(d);
    endfunction

    task automatic model_step();
        int prev;
        prev  = m_sig;
        m_sig = int'(i_sigma);
        if (m_arm == 0) begin
            m_arm = 1;
            return;
        end
        if (!i_enable) begin
            m_mode = 0;
            return;
        end
        case (m_mode)
            0: begin
                m_mode = 1; m_left = dead_len(i_deadtime); m_tgt = prev; m_first = 1;
            end
            1: begin
                m_left--;
                if (m_left == 0) begin
                    if (m_first == 0 && m_tgt != m_pol) m_sw = (m_sw + 1) % (DW_MAX + 1);
                    m_pol = m_tgt; m_first = 0; m_mode = 2; m_age = 0;
                    m_min = int'(i_min_dwell);
                end
            end
            default: begin
                if (prev != m_pol && m_age >= m_min) begin
                    m_mode = 1; m_left = dead_len(i_deadtime); m_tgt = prev;
                end else if (m_age < DW_MAX) begin
                    m_age++;
                end
            end
        endcase
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge i_clock or negedge i_RESET);
            if (!i_RESET) model_reset();
            else model_step();
        end
    end

    // Compare DUT against the model on every falling edge
    initial begin
        logic [3:0] exp_gate;
        forever begin
            @(negedge i_clock);
            exp_gate = (m_mode == 2) ? ((m_pol == 1) ? 4'b1001 : 4'b0110) : 4'b0000;
            check("gate", 32'(o_gate), 32'(exp_gate));
            check("dead", 32'(o_dead), (m_mode == 2) ? 32'd0 : 32'd1);
            check("sigma_applied", 32'(o_sigma_applied), 32'(m_pol));
            check("sw_count", 32'(o_sw_count), 32'(m_sw));
            check("no_overlap", 32'((o_gate[0] & o_gate[1]) | (o_gate[2] & o_gate[3])), 32'd0);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge i_clock);
            #1;
        end
    endtask

    initial begin
        #1 i_RESET = 1'b0;
        tick(2);
        check("rst_gate", 32'(o_gate), 32'd0);
        check("rst_dead", 32'(o_dead), 32'd1);
        check("rst_applied", 32'(o_sigma_applied), 32'd1);
        check("rst_count", 32'(o_sw_count), 32'd0);

        // Start-up: D=5, sigma=1
        i_RESET = 1'b1; i_enable = 1'b1;
        tick(1); check("start_off", 32'(o_gate), 32'd0);
        tick(1); check("start_dead", 32'(o_dead), 32'd1);
        tick(4); check("start_dead_last", 32'(o_gate), 32'd0);
        tick(1); check("start_on_p", 32'(o_gate), 32'h9);
        check("start_count", 32'(o_sw_count), 32'd0);

        // Switch to negative pair with D=3
        i_sigma = 1'b0; i_deadtime = 8'd3;
        tick(1); check("sw1_hold", 32'(o_gate), 32'h9);
        tick(1); check("sw1_dead", 32'(o_gate), 32'd0);
        tick(2); check("sw1_dead_last", 32'(o_gate), 32'd0);
        tick(1); check("sw1_on_n", 32'(o_gate), 32'h6);
        check("sw1_count", 32'(o_sw_count), 32'd1);
        check("sw1_applied", 32'(o_sigma_applied), 32'd0);

        // Zero dead time gives one dead cycle; min dwell 100 sampled on this entry
        i_sigma = 1'b1; i_deadtime = 8'd0; i_min_dwell = 16'd100;
        tick(1); check("d0_hold", 32'(o_gate), 32'h6);
        tick(1); check("d0_dead", 32'(o_gate), 32'd0);
        tick(1); check("d0_on_p", 32'(o_gate), 32'h9);
        check("d0_count", 32'(o_sw_count), 32'd2);

        // Request at dwell=20 is held until dwell=100
        tick(20); i_sigma = 1'b0;
        tick(80); check("dwell_held", 32'(o_gate), 32'h9);
        tick(1);  check("dwell_dead", 32'(o_gate), 32'd0);
        tick(1);  check("dwell_on_n", 32'(o_gate), 32'h6);
        check("dwell_count", 32'(o_sw_count), 32'd3);

        // Request withdrawn before dwell expires
        tick(20); i_sigma = 1'b1;
        tick(30); i_sigma = 1'b0;
        tick(100); check("withdraw_on_n", 32'(o_gate), 32'h6);
        check("withdraw_count", 32'(o_sw_count), 32'd3);

        // Enable drop mid-ON_N, then re-entry from OFF does not count
        i_enable = 1'b0; i_sigma = 1'b1;
        tick(1); check("dis_gate", 32'(o_gate), 32'd0);
        check("dis_applied", 32'(o_sigma_applied), 32'd0);
        i_enable = 1'b1; i_deadtime = 8'd4; i_min_dwell = 16'd0;
        tick(1); check("reen_dead", 32'(o_gate), 32'd0);
        tick(3); check("reen_dead_last", 32'(o_gate), 32'd0);
        tick(1); check("reen_on_p", 32'(o_gate), 32'h9);
        check("reen_count", 32'(o_sw_count), 32'd3);

        // Reset pulse mid-DEAD
        i_sigma = 1'b0; i_deadtime = 8'd5;
        tick(2); check("pre_rst_dead", 32'(o_dead), 32'd1);
        i_RESET = 1'b0;
        #1 check("rst_dead_count", 32'(o_sw_count), 32'd0);
        check("rst_dead_applied", 32'(o_sigma_applied), 32'd1);
        #2 i_RESET = 1'b1;
        tick(6); check("rst_dead_reon_off", 32'(o_gate), 32'd0);
        tick(1); check("rst_dead_on_n", 32'(o_gate), 32'h6);
        check("rst_dead_on_count", 32'(o_sw_count), 32'd0);

        // Reset mid-ON turns gates off without a clock edge
        i_RESET = 1'b0;
        #1 check("rst_on_async", 32'(o_gate), 32'd0);
        #2 i_RESET = 1'b1;
        tick(7); check("rst_on_recover", 32'(o_gate), 32'h6);

        // Counter wrap
        force dut.sw_cnt_q = 16'hFFFF;
        m_sw = DW_MAX;
        #1 release dut.sw_cnt_q;
        i_sigma = 1'b1; i_deadtime = 8'd0;
        tick(1); check("wrap_pre", 32'(o_sw_count), 32'hFFFF);
        tick(1); check("wrap_dead", 32'(o_gate), 32'd0);
        tick(1); check("wrap_on_p", 32'(o_gate), 32'h9);
        check("wrap_count", 32'(o_sw_count), 32'd0);

        // Random sigma run, model-checked every cycle
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 5) == 0) i_sigma = ~i_sigma;
            if ($urandom_range(0, 15) == 0) begin
                i_deadtime  = 8'($urandom_range(0, 3));
                i_min_dwell = 16'($urandom_range(0, 6));
            end
            i_enable = ($urandom_range(0, 199) != 0);
            tick(1);
        end

        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
